// File: rtl/sequencer_pkg.sv
// Types and constants shared by the step editor and the playback path.
package sequencer_pkg;

  localparam int NOTE_W = 4;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_MAX  = 4'd15;

  localparam int BTN_NEXT  = 0;
  localparam int BTN_PREV  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_CLEAR = 4;
  localparam int BTN_N     = 5;

  typedef enum logic {
    ED_IDLE  = 1'b0,
    ED_CLEAR = 1'b1
  } ed_state_e;

  // Saturating one-step pitch change; returns the input unchanged at either rail.
  function automatic logic [NOTE_W-1:0] note_step(input logic [NOTE_W-1:0] note,
                                                  input logic inc);
    logic [NOTE_W-1:0] res;
    if (inc) begin
      res = (note == NOTE_MAX) ? note : note + 4'd1;
    end else begin
      res = (note == NOTE_REST) ? note : note - 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/beat_editor_button_conditioner.sv
// Button front end: 2-flop synchronizer, optional debouncer, registered press pulse.
// The debouncer is built only when BEAT_EDITOR_DEBOUNCE_EN is defined.
module button_conditioner
  import sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic [1:0] sync_r;
  logic       level_s;
  logic       prev_r;
  logic       press_r;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-stage synchronizer for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn};
    end
  end

`ifdef BEAT_EDITOR_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             filt_r;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      filt_r <= 1'b0;
    end else if (sync_r[1] != filt_r) begin
      if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_r <= sync_r[1];
        cnt_r  <= '0;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = sync_r[1];
`endif

  // Rising-edge detector; the pulse is registered so the top sees a clean flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      prev_r  <= level_s;
      press_r <= level_s & ~prev_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/beat_editor.sv
// Step-pattern editor: cursor movement, saturating pitch edits and a clear sweep
// over a flat step register. Define BEAT_EDITOR_DEBOUNCE_EN to debounce the buttons.
module beat_editor
  import sequencer_pkg::*;
#(
  parameter int NUM_BEATS       = 16,
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_next,
  input  logic                          btn_prev,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_clear,
  output logic [NUM_BEATS*NOTE_W-1:0]   beats,
  output logic [$clog2(NUM_BEATS)-1:0]  cursor,
  output logic [NOTE_W-1:0]             cur_note,
  output logic                          busy,
  output logic                          update
);

  localparam int CUR_W   = $clog2(NUM_BEATS);
  localparam int BEATS_W = NUM_BEATS * NOTE_W;

  if (NUM_BEATS < 2 || (NUM_BEATS & (NUM_BEATS - 1)) != 0) begin : g_bad_cfg
    $error("NUM_BEATS must be a power of two, at least 2");
  end

  logic [BTN_N-1:0]   raw_s;
  logic [BTN_N-1:0]   press_s;

  ed_state_e          state_r,  state_s;
  logic [BEATS_W-1:0] beats_r,  beats_s;
  logic [CUR_W-1:0]   cursor_r, cursor_s;
  logic [CUR_W-1:0]   sweep_r,  sweep_s;
  logic               busy_r,   busy_s;
  logic               update_r, update_s;
  logic [NOTE_W-1:0]  cur_note_r;
  logic [NOTE_W-1:0]  note_s;
  logic [NOTE_W-1:0]  stepped_s;

  assign raw_s = {btn_clear, btn_down, btn_up, btn_prev, btn_next};

  for (genvar g = 0; g < BTN_N; g++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (raw_s[g]),
      .press (press_s[g])
    );
  end

  // Next-state logic: one action per cycle, clear > up/down > next/prev
  always_comb begin
    state_s   = state_r;
    beats_s   = beats_r;
    cursor_s  = cursor_r;
    sweep_s   = sweep_r;
    busy_s    = busy_r;
    update_s  = 1'b0;
    note_s    = beats_r[cursor_r*NOTE_W +: NOTE_W];
    stepped_s = note_step(note_s, press_s[BTN_UP]);

    case (state_r)
      ED_IDLE: begin
        if (press_s[BTN_CLEAR]) begin
          state_s = ED_CLEAR;
          busy_s  = 1'b1;
          sweep_s = '0;
        end else if (press_s[BTN_UP] ^ press_s[BTN_DOWN]) begin
          // A press at a rail is consumed but leaves the step untouched
          if (stepped_s != note_s) begin
            beats_s[cursor_r*NOTE_W +: NOTE_W] = stepped_s;
            update_s = 1'b1;
          end else begin
            update_s = 1'b0;
          end
        end else if (press_s[BTN_NEXT] ^ press_s[BTN_PREV]) begin
          if (press_s[BTN_NEXT]) begin
            cursor_s = cursor_r + CUR_W'(1);
          end else begin
            cursor_s = cursor_r - CUR_W'(1);
          end
        end else begin
          state_s = ED_IDLE;
        end
      end
      ED_CLEAR: begin
        beats_s[sweep_r*NOTE_W +: NOTE_W] = NOTE_REST;
        if (sweep_r == CUR_W'(NUM_BEATS - 1)) begin
          state_s  = ED_IDLE;
          busy_s   = 1'b0;
          update_s = 1'b1;
          sweep_s  = '0;
        end else begin
          sweep_s = sweep_r + CUR_W'(1);
        end
      end
      default: begin
        state_s = ED_IDLE;
        busy_s  = 1'b0;
        sweep_s = '0;
      end
    endcase
  end

  // Editor state, step buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ED_IDLE;
      beats_r    <= '0;
      cursor_r   <= '0;
      sweep_r    <= '0;
      busy_r     <= 1'b0;
      update_r   <= 1'b0;
      cur_note_r <= NOTE_REST;
    end else begin
      state_r    <= state_s;
      beats_r    <= beats_s;
      cursor_r   <= cursor_s;
      sweep_r    <= sweep_s;
      busy_r     <= busy_s;
      update_r   <= update_s;
      cur_note_r <= beats_r[cursor_r*NOTE_W +: NOTE_W];
    end
  end

  assign beats    = beats_r;
  assign cursor   = cursor_r;
  assign cur_note = cur_note_r;
  assign busy     = busy_r;
  assign update   = update_r;

endmodule

// File: tb/tb_beat_editor.sv
// Bench for beat_editor: directed scenarios plus random button traffic, all checked
// every cycle against a behavioural step-buffer model.
module tb_beat_editor;

  localparam int NB  = 16;
  localparam int DEB = 8;
`ifdef BEAT_EDITOR_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int HOLD = DB ? 12 : 2;
  localparam int GAP  = DB ? 12 : 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  btn_v;   // 0 next, 1 prev, 2 up, 3 down, 4 clear
  logic [63:0] beats;
  logic [3:0]  cursor;
  logic [3:0]  cur_note;
  logic        busy;
  logic        update;

  always #5 clk = ~clk;

  beat_editor #(
    .NUM_BEATS       (NB),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_v[0]),
    .btn_prev  (btn_v[1]),
    .btn_up    (btn_v[2]),
    .btn_down  (btn_v[3]),
    .btn_clear (btn_v[4]),
    .beats     (beats),
    .cursor    (cursor),
    .cur_note  (cur_note),
    .busy      (busy),
    .update    (update)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         bm[NB];
  int         cur_m, busy_m, sweep_m, upd_m, cn_m;
  logic [4:0] s_h[4];
  logic [4:0] l_h[4];
  logic [4:0] filt_m;
  int         run_m[5];
  int         upd_cnt, busy_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) bm[i] = 0;
    cur_m = 0; busy_m = 0; sweep_m = 0; upd_m = 0; cn_m = 0;
    for (int i = 0; i < 4; i++) begin
      s_h[i] = 5'd0;
      l_h[i] = 5'd0;
    end
    filt_m = 5'd0;
    for (int i = 0; i < 5; i++) run_m[i] = 0;
  endtask

  function automatic logic [63:0] beats_exp();
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < NB; i++) r[i*4 +: 4] = bm[i][3:0];
    return r;
  endfunction

  // One clock edge of the behavioural model
  task automatic model_edge();
    logic [4:0] lnew;
    logic [4:0] pr;
    int n;
    pr = l_h[1] & ~l_h[2];
    if (DB) begin
      for (int b = 0; b < 5; b++) begin
        if (s_h[1][b] !== filt_m[b]) begin
          run_m[b]++;
          if (run_m[b] == DEB) begin
            filt_m[b] = s_h[1][b];
            run_m[b] = 0;
          end
        end else begin
          run_m[b] = 0;
        end
      end
      lnew = filt_m;
    end else begin
      lnew = s_h[0];
    end
    for (int i = 3; i > 0; i--) begin
      s_h[i] = s_h[i-1];
      l_h[i] = l_h[i-1];
    end
    s_h[0] = btn_v;
    l_h[0] = lnew;

    cn_m  = bm[cur_m];
    upd_m = 0;
    if (busy_m != 0) begin
      bm[sweep_m] = 0;
      if (sweep_m == NB - 1) begin
        busy_m = 0;
        upd_m  = 1;
      end
      sweep_m++;
    end else if (pr[4]) begin
      busy_m  = 1;
      sweep_m = 0;
    end else if (pr[2] != pr[3]) begin
      n = bm[cur_m] + (pr[2] ? 1 : -1);
      if (n >= 0 && n <= 15) begin
        bm[cur_m] = n;
        upd_m = 1;
      end
    end else if (pr[0] != pr[1]) begin
      cur_m = (cur_m + (pr[0] ? 1 : NB - 1)) % NB;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("beats",    beats,    beats_exp());
    check("cursor",   cursor,   64'(cur_m));
    check("cur_note", cur_note, 64'(cn_m));
    check("busy",     busy,     64'(busy_m));
    check("update",   update,   64'(upd_m));
    upd_cnt  += int'(update);
    busy_cnt += int'(busy);
  endtask

  task automatic press(input int idx);
    btn_v[idx] = 1'b1;
    repeat (HOLD) cycle();
    btn_v[idx] = 1'b0;
    repeat (GAP) cycle();
  endtask

  initial begin
    logic [31:0] r;
    int hold;
    rst_n = 1'b0;
    btn_v = 5'd0;
    model_reset();
    upd_cnt = 0;
    busy_cnt = 0;
    #12;
    check("rst_beats",  beats,    64'd0);
    check("rst_cursor", cursor,   64'd0);
    check("rst_note",   cur_note, 64'd0);
    check("rst_busy",   busy,     64'd0);
    check("rst_update", update,   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two increments on step 0
    upd_cnt = 0;
    press(2);
    press(2);
    check("t1_updates", 64'(upd_cnt), 64'd2);
    check("t1_step0",   beats[3:0],  64'd2);
    check("t1_curnote", cur_note,    64'd2);
    check("t1_others",  beats[63:4], 64'd0);

    // Cursor wrap both ways
    press(1);
    check("t2_wrap_prev", cursor, 64'd15);
    press(0);
    check("t2_wrap_next", cursor, 64'd0);

    // Saturation at 15 and at 0
    repeat (5) press(0);
    repeat (15) press(2);
    upd_cnt = 0;
    press(2);
    check("t3_sat_upd",  64'(upd_cnt), 64'd0);
    check("t3_sat_high", beats[23:20], 64'd15);
    press(0);
    upd_cnt = 0;
    press(3);
    check("t3_floor_upd", 64'(upd_cnt), 64'd0);
    check("t3_floor",     beats[27:24], 64'd0);

    // Fill steps 0..3, then clear while holding up
    repeat (6) press(1);
    press(2);
    press(0); press(2);
    press(0); press(2); press(2);
    press(0); press(2);
    check("t4_fill", beats[15:0], 64'h1213);
    busy_cnt = 0;
    upd_cnt  = 0;
    btn_v = 5'b10100;
    repeat (HOLD) cycle();
    btn_v = 5'b00100;
    repeat (30) cycle();
    btn_v = 5'd0;
    repeat (GAP) cycle();
    check("t4_busy_len", 64'(busy_cnt), 64'd16);
    check("t4_cleared",  beats,         64'd0);
    check("t4_cursor",   cursor,        64'd3);
    check("t4_updates",  64'(upd_cnt),  64'd1);

    // Short glitch then a long press on step 3
    btn_v[2] = 1'b1;
    repeat (5) cycle();
    btn_v[2] = 1'b0;
    repeat (GAP) cycle();
    btn_v[2] = 1'b1;
    repeat (20) cycle();
    btn_v[2] = 1'b0;
    repeat (GAP + 4) cycle();
    check("t5_glitch", beats[15:12], DB ? 64'd1 : 64'd2);

    // Asynchronous reset in the middle of a sweep
    btn_v[4] = 1'b1;
    for (int i = 0; i < 40 && !busy; i++) cycle();
    check("t6_busy_seen", busy, 64'd1);
    btn_v[4] = 1'b0;
    repeat (8) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_beats",  beats,  64'd0);
    check("t6_busy",   busy,   64'd0);
    check("t6_cursor", cursor, 64'd0);
    check("t6_update", update, 64'd0);
    @(posedge clk);
    @(negedge clk);
    btn_v = 5'd0;
    model_reset();
    rst_n = 1'b1;

    // Random button traffic
    for (int it = 0; it < 250; it++) begin
      r = $urandom;
      btn_v = r[4:0];
      if ($urandom_range(0, 15) != 0) btn_v[4] = 1'b0;
      if ($urandom_range(0, 3) == 0) btn_v = 5'd0;
      hold = $urandom_range(1, DB ? 24 : 5);
      repeat (hold) cycle();
    end
    btn_v = 5'd0;
    repeat (GAP + 20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/beat_editor.md
# beat_editor

Pattern editor that writes the sequencer's step buffer: conditions five front-panel buttons, moves an edit cursor across the steps, and raises, lowers or clears the 4-bit pitch stored at each step. Its packed `beats` output is the same NUM_BEATS×4 vector that the playback path (`audio_controller`) reads. It sits between the board button pins and the playback controller.

## Interface
- NUM_BEATS, 16: number of steps; power of two, at least 2.
- DEBOUNCE_CYCLES, 120_000: number of consecutive stable samples needed to accept a level change (10 ms at 12 MHz). Used only when BEAT_EDITOR_DEBOUNCE_EN is defined.
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- btn_next, btn_prev, btn_up, btn_down, btn_clear  in  1 each  raw active-high buttons, asynchronous to clk
- beats  out  NUM_BEATS*4  packed pitches; step i occupies bits [i*4 +: 4]; pitch 0 is a rest
- cursor  out  $clog2(NUM_BEATS)  step currently being edited
- cur_note  out  4  equals beats[cursor*4 +: 4], registered
- busy  out  1  high while a clear sweep runs
- update  out  1  one-cycle pulse in the cycle after any write to beats

## Operation
- Every output is 0 at reset: beats, cursor, cur_note, busy and update.
- Each button passes through a 2-flop synchronizer, then an optional debouncer, then a rising-edge detector that produces a 1-cycle press pulse.
- States:
  - IDLE: accepts press pulses.
  - CLEAR: sweeps the buffer.
- IDLE, priority order (highest first):
  1. clear → go to CLEAR, set busy = 1, sweep index = 0.
  2. up or down, exactly one of them → change the step at the cursor. Up saturates at 15; down saturates at 0. up and down together do nothing. A press that hits saturation writes nothing and produces no update pulse.
  3. next or prev, exactly one of them → cursor ±1, wrapping modulo NUM_BEATS (NUM_BEATS-1 next → 0; 0 prev → NUM_BEATS-1). next and prev together do nothing.
- Only the single highest-priority action executes in a given cycle. Lower-priority pulses in that cycle are dropped, not queued.
- CLEAR:
  - Writes 0 to step[sweep index], one step per cycle, for NUM_BEATS cycles.
  - After the last step: busy = 0 and return to IDLE.
  - All press pulses are dropped while busy.
  - The cursor does not change.
  - update pulses once, in the cycle after the final sweep write.
- Reset asserted mid-sweep: all state returns to reset values immediately. The sweep is not resumed.

## Timing
- Press latency with the macro off: a raw rising edge sampled at clk edge 0 is visible in beats/cursor after edge 3 (sync ×2, then the action register). update is high during the cycle following edge 3.
- Press latency with the macro on: as above plus DEBOUNCE_CYCLES.
- cur_note follows beats/cursor with one extra cycle of latency.
- A clear press that reaches IDLE at cycle t:
  - busy goes high at t+1.
  - Steps 0..NUM_BEATS-1 are written at t+1..t+NUM_BEATS.
  - busy falls at t+NUM_BEATS+1.
- A button held high produces exactly one action; there is no auto-repeat.

## Configuration
- BEAT_EDITOR_DEBOUNCE_EN defined:
  - Each synchronized button feeds a counter that restarts whenever the input differs from the filtered level.
  - The filtered level flips after DEBOUNCE_CYCLES consecutive differing samples.
  - Bounces shorter than this produce no pulse.
- Not defined: no counters are instantiated. The synchronized level drives the edge detector directly, and the DEBOUNCE_CYCLES parameter is unused.

## Structure
- `sequencer_pkg` holds:
  - NOTE_W = 4 and NOTE_REST = 4'd0, shared with the playback path.
  - NOTE_MAX = 4'd15.
  - The editor state enum (ED_IDLE, ED_CLEAR).
- One sub-module, `button_conditioner`, instantiated once per button: synchronizer, optional debouncer, edge pulse. It takes DEBOUNCE_CYCLES as a parameter and the same clk/rst_n.
- The step buffer stays as a flat register in beat_editor; no RAM inference.

## Test plan
- Reset, then 2× btn_up on step 0 → beats[3:0]=2 and cur_note=2; update pulses twice; every other step stays 0.
- btn_prev from cursor 0 → cursor=15 (NUM_BEATS=16). btn_next from 15 → cursor=0.
- 16× btn_up on one step → value saturates at 15; the 16th press produces no update. btn_down at 0 → stays 0, no update.
- Fill steps 0..3 with nonzero values, press clear, and hold btn_up during the sweep:
  - busy stays high for exactly 16 cycles.
  - beats ends all-zero and cursor is unchanged.
  - btn_up has no effect while busy.
- With the macro defined and DEBOUNCE_CYCLES=8, apply a 5-cycle glitch then a 20-cycle press → exactly one increment. Same press with the macro undefined → increment after edge 3.
- Deassert rst_n halfway through a clear sweep → beats, busy and cursor read 0 immediately, without waiting for a clk edge.
